alu_sequencer: RTL
==================

# alu_sequencer

Issue and write-back controller that sits directly upstream of the ALU. It holds a small operand register file and accepts one instruction at a time through a valid/ready handshake. For each instruction it drives registered operands, `c_in` and `select` into the ALU, captures the ALU's combinational `y`, and writes the result back to a destination register. It also rejects select codes the ALU does not implement.

## Interface

Parameters:
- `WIDTH`, default 4: data width; equals the ALU `width`.
- `SEL_WIDTH`, default 5: select width; equals the ALU `sel_width`.
- Register file size is fixed at 4 entries with 2-bit addresses; this is not a parameter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  an instruction is offered.
- `instr_ready`  out  1  the block can accept an instruction.
- `instr_sel`  in  SEL_WIDTH  ALU select code.
- `instr_cin`  in  1  ALU `c_in`.
- `instr_rd`  in  2  destination register.
- `instr_rs1`  in  2  register driven to ALU `a`.
- `instr_rs2`  in  2  register driven to ALU `b`.
- `load_en`  in  1  direct register write request.
- `load_addr`  in  2  register to load.
- `load_data`  in  WIDTH  value to load.
- `alu_a`  out  WIDTH  registered operand to ALU `a`.
- `alu_b`  out  WIDTH  registered operand to ALU `b`.
- `alu_c_in`  out  1  registered, to ALU `c_in`.
- `alu_select`  out  SEL_WIDTH  registered, to ALU `select`.
- `alu_y`  in  WIDTH  ALU result (combinational).
- `result`  out  WIDTH  last captured ALU result.
- `zero`  out  1  `result == 0`, updated at write-back.
- `done`  out  1  one-cycle pulse, write-back performed.
- `err`  out  1  one-cycle pulse, illegal select rejected.
- `dbg_addr`  in  2  register file read address.
- `dbg_data`  out  WIDTH  combinational `R[dbg_addr]`.

## Operation

- FSM states: IDLE, EXEC, WB.
- IDLE → EXEC when `instr_valid & instr_ready` and `instr_sel` is legal:
  - latch `alu_a <= R[rs1]`, `alu_b <= R[rs2]`, `alu_c_in`, `alu_select`, and `rd`.
- IDLE with an illegal select:
  - the instruction is consumed and the state stays IDLE.
  - `err` pulses in the next cycle.
  - no ALU port change, no write-back, no `done`.
- Legal select codes: 0–8, 16, 24, 25. All others are illegal.
- EXEC → WB unconditionally; capture `result <= alu_y`.
- WB → IDLE unconditionally:
  - `R[rd] <= result`
  - `zero <= (result == 0)`
  - `done` asserted for the following cycle.
- `instr_ready = (state == IDLE) & ~rst`.
- `load_en` takes effect only in IDLE and is ignored in EXEC and WB.
  - If a load and an accepted instruction share an edge, both occur. The instruction samples the pre-load register values.
- ALU ports hold their last issued values between instructions; the block never drives them combinationally.
- Arithmetic is performed entirely by the ALU. The block does not modify or extend `alu_y`: WIDTH bits in, WIDTH bits stored, carry-out discarded.

## Timing

- Reset values: state IDLE; R[0..3] = 0; `alu_a`, `alu_b`, `alu_c_in`, `alu_select`, `result`, `zero`, `done`, `err` all 0.
- Accept at edge E0 (`instr_valid` and `instr_ready` both high):
  - ALU inputs are valid from E0 until the next issue.
  - `result` updates at E1.
  - `R[rd]`, `zero` and `done` update at E2.
  - `instr_ready` returns high after E2, so the next accept is at E3 earliest.
- Throughput is one instruction per 3 cycles; `instr_ready` is low for exactly 2 cycles after an accept.
- Read-after-write needs no forwarding: an instruction accepted at E3 reads the `R[rd]` written at E2.
- Reset mid-operation:
  - the FSM returns to IDLE and the in-flight instruction is abandoned.
  - no `done` or `err`, and registers are cleared.
  - `instr_ready` is high in the first cycle with `rst` low.
- `rst` and `instr_valid` in the same cycle: the instruction is not accepted.
- `done` and `err` are never high simultaneously.

## Test plan

- Add:
  - stimulus: load R1=4'hA, R2=4'h5, then issue sel=1, cin=0, rs1=1, rs2=2, rd=3.
  - response: after E0, `alu_a`=A and `alu_b`=5; `result`=F after E1; after E2, R3=F, `zero`=0, `done` pulses once.
- Subtract:
  - stimulus: R1=5, R2=5; issue sel=2, cin=1, rs1=1, rs2=2, rd=0.
  - response: R0=0, `zero`=1.
  - repeat with sel=25, cin=0 (complement b): R0=A.
- Back-to-back:
  - stimulus: hold `instr_valid` high for R3=R1+R2 (sel=1), then R3=R3+R1 with R1=1, R2=2.
  - response: `instr_ready` low for 2 cycles after each accept; final R3=4; `done` pulses exactly twice.
- Illegal select:
  - stimulus: sel=9.
  - response: `err` pulses once; no `done`; R0..R3 and ALU ports unchanged; `instr_ready` high the next cycle.
- Reset in EXEC:
  - stimulus: assert `rst` for one cycle during EXEC.
  - response: no `done`; all registers and outputs 0; `instr_ready`=1 on the first cycle after `rst` falls.
- Load conflicts:
  - stimulus: `load_en` with R2=7 during EXEC.
  - response: ignored, R2 unchanged.
  - stimulus: load R1=7 on the same edge as an accept with rs1=1 and old R1=2.
  - response: `alu_a`=2, and R1=7 afterwards.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction, load, debug and ALU-facing signals of the sequencer
interface alu_sequencer_if #(
    parameter int WIDTH     = 4,
    parameter int SEL_WIDTH = 5
);
    logic                 instr_valid;
    logic                 instr_ready;
    logic [SEL_WIDTH-1:0] instr_sel;
    logic                 instr_cin;
    logic [1:0]           instr_rd;
    logic [1:0]           instr_rs1;
    logic [1:0]           instr_rs2;
    logic                 load_en;
    logic [1:0]           load_addr;
    logic [WIDTH-1:0]     load_data;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic                 alu_c_in;
    logic [SEL_WIDTH-1:0] alu_select;
    logic [WIDTH-1:0]     alu_y;
    logic [WIDTH-1:0]     result;
    logic                 zero;
    logic                 done;
    logic                 err;
    logic [1:0]           dbg_addr;
    logic [WIDTH-1:0]     dbg_data;
    modport master (
        output instr_valid, instr_sel, instr_cin, instr_rd, instr_rs1, instr_rs2,
               load_en, load_addr, load_data, alu_y, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_c_in, alu_select, result, zero, done, err, dbg_data
    );
    modport slave (
        input  instr_valid, instr_sel, instr_cin, instr_rd, instr_rs1, instr_rs2,
               load_en, load_addr, load_data, alu_y, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_c_in, alu_select, result, zero, done, err, dbg_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues register-file operands to an external ALU and writes its result back
module alu_sequencer #(
    parameter int WIDTH     = 4,
    parameter int SEL_WIDTH = 5
) (
    input logic           clk,
    input logic           rst,
    alu_sequencer_if.slave io_bus
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_regs [4];
    logic [1:0]           r_rd;
    logic [WIDTH-1:0]     r_alu_a;
    logic [WIDTH-1:0]     r_alu_b;
    logic                 r_alu_c_in;
    logic [SEL_WIDTH-1:0] r_alu_select;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic                 r_done;
    logic                 r_err;
    logic                 w_accept;
    logic                 w_legal;
    logic                 w_issue;
    assign io_bus.instr_ready = (r_state == IDLE) & ~rst;
    assign w_accept = io_bus.instr_valid & io_bus.instr_ready;
    assign w_legal  = (io_bus.instr_sel <= SEL_WIDTH'(8)) | (io_bus.instr_sel == SEL_WIDTH'(16)) |
                      (io_bus.instr_sel == SEL_WIDTH'(24)) | (io_bus.instr_sel == SEL_WIDTH'(25));
    assign w_issue  = w_accept & w_legal;
    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE) ? (w_issue ? EXEC : IDLE) : (r_state == EXEC) ? WB : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // Nonblocking writes let an accept on the same edge as a load read the pre-load value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs       <= '{default: '0};
            r_rd         <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_c_in   <= 1'b0;
            r_alu_select <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_accept & ~w_legal;
            if (r_state == IDLE && io_bus.load_en) r_regs[io_bus.load_addr] <= io_bus.load_data;
            if (w_issue) begin
                r_alu_a      <= r_regs[io_bus.instr_rs1];
                r_alu_b      <= r_regs[io_bus.instr_rs2];
                r_alu_c_in   <= io_bus.instr_cin;
                r_alu_select <= io_bus.instr_sel;
                r_rd         <= io_bus.instr_rd;
            end
            if (r_state == EXEC) r_result <= io_bus.alu_y;
            if (r_state == WB) begin
                r_regs[r_rd] <= r_result;
                r_zero       <= (r_result == '0);
                r_done       <= 1'b1;
            end
        end
    end
    assign io_bus.alu_a      = r_alu_a;
    assign io_bus.alu_b      = r_alu_b;
    assign io_bus.alu_c_in   = r_alu_c_in;
    assign io_bus.alu_select = r_alu_select;
    assign io_bus.result     = r_result;
    assign io_bus.zero       = r_zero;
    assign io_bus.done       = r_done;
    assign io_bus.err        = r_err;
    assign io_bus.dbg_data   = r_regs[io_bus.dbg_addr];
endmodule
